// File: rtl/aes_round_ctrl.sv
// AES round sequencer: waits out key expansion after a new cipher key, then
// walks one block through the round datapath and hands it off over valid/ready.
module aes_round_ctrl #(
    parameter int KEXP_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       k_ready,
    input  logic [3:0] Nk,
    input  logic       dec,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic [3:0] key_addr,
    output logic       rnd_load,
    output logic       rnd_en,
    output logic       rnd_last,
    output logic       busy,
    output logic       key_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KEY_EXP = 3'd1,
        READY   = 3'd2,
        ROUND   = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       kr_q;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] r_q, r_d;
    logic [3:0] ka_q, ka_d;
    logic       dec_q, dec_d;
    logic       key_err_q, key_err_d;
    logic       k_edge;
    logic       nk_legal;

    // Encrypt walks keys upward from 0, decrypt walks downward from Nr.
    function automatic logic [3:0] round_key_addr(input logic       d,
                                                  input logic [3:0] nr,
                                                  input logic [3:0] r);
        return d ? (nr - r) : r;
    endfunction

    assign k_edge   = k_ready & ~kr_q;
    assign nk_legal = (Nk == 4'd4) || (Nk == 4'd6) || (Nk == 4'd8);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nr_d       = nr_q;
        r_d        = r_q;
        ka_d       = ka_q;
        dec_d      = dec_q;
        key_err_d  = key_err_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        rnd_load   = 1'b0;
        rnd_en     = 1'b0;
        rnd_last   = 1'b0;
        key_addr   = 4'd0;

        case (state_q)
            KEY_EXP: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = READY;
                end
            end
            READY: begin
                din_ready = 1'b1;
                key_addr  = dec ? nr_q : 4'd0;
                if (din_valid) begin
                    rnd_load = 1'b1;
                    dec_d    = dec;
                    r_d      = 4'd1;
                    ka_d     = round_key_addr(dec, nr_q, 4'd1);
                    state_d  = ROUND;
                end
            end
            ROUND: begin
                rnd_en   = 1'b1;
                key_addr = ka_q;
                rnd_last = (r_q == nr_q);
                if (r_q == nr_q) begin
                    state_d = OUT;
                end else begin
                    r_d  = r_q + 4'd1;
                    ka_d = round_key_addr(dec_q, nr_q, r_q + 4'd1);
                end
            end
            OUT: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    state_d = READY;
                end
            end
            default: ;
        endcase

        // A new key overrides everything, including a same-cycle input handshake.
        if (k_edge) begin
            rnd_load = 1'b0;
            if (nk_legal) begin
                nr_d      = Nk + 4'd6;
                key_err_d = 1'b0;
                cnt_d     = 8'(KEXP_CYCLES);
                state_d   = KEY_EXP;
            end else begin
                key_err_d = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            kr_q      <= 1'b0;
            cnt_q     <= 8'd0;
            nr_q      <= 4'd0;
            r_q       <= 4'd0;
            ka_q      <= 4'd0;
            dec_q     <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kr_q      <= k_ready;
            cnt_q     <= cnt_d;
            nr_q      <= nr_d;
            r_q       <= r_d;
            ka_q      <= ka_d;
            dec_q     <= dec_d;
            key_err_q <= key_err_d;
        end
    end

    assign busy    = (state_q == KEY_EXP) || (state_q == ROUND) || (state_q == OUT);
    assign key_err = key_err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_aes_round_ctrl;

    localparam int KEXP = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       k_ready = 1'b0;
    logic [3:0] Nk = 4'd4;
    logic       dec = 1'b0;
    logic       din_valid = 1'b0;
    logic       dout_ready = 1'b0;
    logic       din_ready, dout_valid, rnd_load, rnd_en, rnd_last, busy, key_err;
    logic [3:0] key_addr;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    aes_round_ctrl #(.KEXP_CYCLES(KEXP)) dut (
        .clk        (clk),
        .rst        (rst),
        .k_ready    (k_ready),
        .Nk         (Nk),
        .dec        (dec),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .key_addr   (key_addr),
        .rnd_load   (rnd_load),
        .rnd_en     (rnd_en),
        .rnd_last   (rnd_last),
        .busy       (busy),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Model: phase is derived from when the key arrived and when the block started.
    int cyc = 0;
    int key_done = 0;
    int blk_t = 0;
    int nr_m = 0;
    bit kr_prev = 1'b0;
    bit have_key = 1'b0;
    bit key_bad = 1'b0;
    bit blk = 1'b0;
    bit dec_m = 1'b0;

    initial begin : model
        logic [10:0] want;
        logic [10:0] act;
        bit kedge, exp_ph, rdy_ph, rnd_ph, out_ph;
        int r;
        while (!done) begin
            @(negedge clk);
            want = '0;
            if (rst) begin
                kr_prev  = 1'b0;
                have_key = 1'b0;
                key_bad  = 1'b0;
                blk      = 1'b0;
            end else begin
                kedge  = k_ready && !kr_prev;
                exp_ph = have_key && (cyc < key_done);
                rdy_ph = have_key && !exp_ph && !blk;
                r      = cyc - blk_t;
                rnd_ph = have_key && !exp_ph && blk && (r <= nr_m);
                out_ph = have_key && !exp_ph && blk && (r > nr_m);
                want[4] = key_bad;
                if (exp_ph) want[5] = 1'b1;
                if (rdy_ph) begin
                    want[10]  = 1'b1;
                    want[8]   = din_valid && !kedge;
                    want[3:0] = dec ? 4'(nr_m) : 4'd0;
                end
                if (rnd_ph) begin
                    want[7]   = 1'b1;
                    want[5]   = 1'b1;
                    want[6]   = (r == nr_m);
                    want[3:0] = dec_m ? 4'(nr_m - r) : 4'(r);
                end
                if (out_ph) begin
                    want[9] = 1'b1;
                    want[5] = 1'b1;
                end
                if (kedge) begin
                    blk = 1'b0;
                    if (Nk == 4'd4 || Nk == 4'd6 || Nk == 4'd8) begin
                        have_key = 1'b1;
                        key_bad  = 1'b0;
                        nr_m     = int'(Nk) + 6;
                        key_done = cyc + KEXP + 1;
                    end else begin
                        have_key = 1'b0;
                        key_bad  = 1'b1;
                    end
                end else if (rdy_ph && din_valid) begin
                    blk   = 1'b1;
                    blk_t = cyc;
                    dec_m = dec;
                end else if (out_ph && dout_ready) begin
                    blk = 1'b0;
                end
                kr_prev = k_ready;
            end
            act = {din_ready, dout_valid, rnd_load, rnd_en, rnd_last, busy, key_err, key_addr};
            chk("cycle_outputs", 32'(act), 32'(want));
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drops k_ready for one cycle, then raises it with the given Nk.
    task automatic key_edge(input logic [3:0] nk);
        tick();
        k_ready = 1'b0;
        Nk = nk;
        tick();
        k_ready = 1'b1;
    endtask

    // Called in the edge cycle; returns at the negedge of the first READY cycle.
    task automatic wait_ready(input int want);
        int n = 0;
        int guard = 0;
        int stray = 0;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        do begin
            @(negedge clk);
            if (busy) n++;
            if (rnd_en || dout_valid || rnd_load) stray++;
            guard++;
        end while (!din_ready && guard < 1000);
        chk("kexp_dwell", 32'(n), 32'(want));
        chk("ready_after_kexp", 32'(din_ready), 1);
        chk("no_round_during_kexp", 32'(stray), 0);
    endtask

    task automatic do_block(input bit dv, input int nr, input int hold);
        tick();
        din_valid = 1'b1;
        dec = dv;
        @(negedge clk);
        chk("rnd_load_at_T", 32'(rnd_load), 1);
        chk("ready_key_addr", 32'(key_addr), dv ? nr : 0);
        for (int i = 1; i <= nr; i++) begin
            tick();
            din_valid = 1'b0;
            dec = ~dv;
            @(negedge clk);
            chk("round_key_addr", 32'(key_addr), dv ? nr - i : i);
            chk("rnd_last", 32'(rnd_last), 32'(i == nr));
            chk("rnd_en", 32'(rnd_en), 1);
        end
        tick();
        @(negedge clk);
        chk("dout_valid_latency", 32'(dout_valid), 1);
        chk("no_din_ready_in_out", 32'(din_ready), 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            @(negedge clk);
            chk("dout_held", 32'(dout_valid), 1);
            chk("din_ready_held_low", 32'(din_ready), 0);
        end
        tick();
        dout_ready = 1'b1;
        @(negedge clk);
        chk("dout_valid_at_accept", 32'(dout_valid), 1);
        tick();
        dout_ready = 1'b0;
        @(negedge clk);
        chk("ready_after_out", 32'(din_ready), 1);
        chk("dout_valid_cleared", 32'(dout_valid), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        @(negedge clk);
        chk("reset_din_ready", 32'(din_ready), 0);
        chk("reset_key_addr", 32'(key_addr), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_key_err", 32'(key_err), 0);
        tick();
        rst = 1'b0;

        // AES-128 encrypt, then the same with a stalled consumer
        key_edge(4'd4);
        wait_ready(KEXP);
        do_block(1'b0, 10, 0);
        do_block(1'b0, 10, 4);

        // AES-256 decrypt
        key_edge(4'd8);
        wait_ready(KEXP);
        do_block(1'b1, 14, 0);

        // Illegal Nk, then recovery with AES-192
        key_edge(4'd5);
        tick();
        @(negedge clk);
        chk("illegal_key_err", 32'(key_err), 1);
        chk("illegal_din_ready", 32'(din_ready), 0);
        chk("illegal_busy", 32'(busy), 0);
        key_edge(4'd6);
        wait_ready(KEXP);
        chk("key_err_cleared", 32'(key_err), 0);
        do_block(1'b0, 12, 0);

        // New key while round 4 is in flight
        tick();
        din_valid = 1'b1;
        dec = 1'b0;
        k_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            din_valid = 1'b0;
        end
        k_ready = 1'b1;
        @(negedge clk);
        chk("abort_round4_addr", 32'(key_addr), 4);
        wait_ready(KEXP);

        // Key edge coincident with an input handshake drops the block
        tick();
        k_ready = 1'b0;
        tick();
        k_ready = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        chk("rnd_load_suppressed", 32'(rnd_load), 0);
        wait_ready(KEXP);

        // Asynchronous reset while a result waits in OUT
        tick();
        din_valid = 1'b1;
        k_ready = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            din_valid = 1'b0;
        end
        #1;
        chk("out_before_rst", 32'(dout_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_key_addr", 32'(key_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_after_rst", 32'(din_ready), 0);

        key_edge(4'd4);
        wait_ready(KEXP);
        do_block(1'b0, 10, 0);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
